decoder_scan_n: RTL and testbench

Parametrised registered SEL_W-to-2^SEL_W one-hot decoder with enable and selectable output polarity. Adds an auto-scan mode that steps the active output through indices 0..LAST at a prescaled rate. Drives multiplexed 7-segment digit enables and LED banks on Elbert V2. Replaces hand-written fixed-width decoders in new designs.

---
 rtl/decoder_scan_n.sv | 132 +++++++++++++
 tb/tb_decoder_scan_n.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// decoder_scan_n
//   Registered SEL_W-to-2^SEL_W one-hot decoder with enable, selectable output
//   polarity and an auto-scan mode. Auto-scan steps the active output through
//   indices 0..LAST at one step every PRESCALE clocks. Intended for
//   multiplexed 7-segment digit enables and LED banks.
//
// Optional build macro: DECODER_DEADTIME_EN
//   When defined, every scan advance gets one blanking cycle. In that cycle
//   tick=1, z is all inactive and idx already shows the new index. This
//   prevents ghosting on multiplexed displays. Direct mode is unaffected.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous reset, active-high, overrides all inputs
//   en      in   global enable
//   mode    in   0 = direct decode of sel, 1 = auto-scan
//   sel     in   [SEL_W-1:0] index decoded in direct mode
//   z       out  [2^SEL_W-1:0] registered one-hot (one-cold if ACTIVE_LOW)
//   idx     out  [SEL_W-1:0] registered index currently driven on z
//   en_out  out  en delayed one cycle, aligned with z
//   tick    out  one-cycle pulse when the scan index advances
module decoder_scan_n #(
  parameter int SEL_W      = 2,
  parameter int LAST       = (1 << SEL_W) - 1,
  parameter int PRESCALE   = 12000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [(1 << SEL_W)-1:0]   z,
  output logic [SEL_W-1:0]          idx,
  output logic                      en_out,
  output logic                      tick
);

  localparam int OUT_W  = 1 << SEL_W;
  localparam int LAST_C = (LAST > OUT_W - 1) ? OUT_W - 1 : LAST;
  localparam int PRE_C  = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int PRE_W  = (PRE_C > 1) ? $clog2(PRE_C) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRE_C - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST_C);
  localparam logic [OUT_W-1:0] Z_IDLE   = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] HOT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] pre_q,    pre_d;
  logic [SEL_W-1:0] scan_q,   scan_d;
  logic             mode_q,   mode_d;
  logic [OUT_W-1:0] z_q,      z_d;
  logic [SEL_W-1:0] idx_q,    idx_d;
  logic             en_out_q, en_out_d;
  logic             tick_q,   tick_d;

  logic [OUT_W-1:0] hot;
  logic             blank;

  always_comb begin
    pre_d    = pre_q;
    scan_d   = scan_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    en_out_d = en;
    tick_d   = 1'b0;
    hot      = '0;
    blank    = 1'b0;
    z_d      = Z_IDLE;

    if (en) begin
      // mode_q only follows mode while enabled, so a 0->1 change made during
      // a pause is still seen as a restart on the first enabled cycle.
      mode_d = mode;
      if (!mode) begin
        pre_d  = '0;
        scan_d = '0;
        idx_d  = sel;
        hot    = HOT_ONE << sel;
      end else if (!mode_q) begin
        // Entering scan: show index 0 now and start counting from 0 next
        // cycle so index 0 gets a full PRESCALE period.
        pre_d  = '0;
        scan_d = '0;
        idx_d  = '0;
        hot    = HOT_ONE;
      end else begin
        if (pre_q == PRE_MAX) begin
          pre_d  = '0;
          tick_d = 1'b1;
          scan_d = (scan_q == LAST_IDX) ? '0 : scan_q + 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
        idx_d = scan_d;
        hot   = HOT_ONE << scan_d;
`ifdef DECODER_DEADTIME_EN
        blank = tick_d;
`else
        blank = 1'b0;
`endif
      end
      z_d = blank ? Z_IDLE : (ACTIVE_LOW ? ~hot : hot);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      scan_q   <= '0;
      mode_q   <= 1'b0;
      z_q      <= Z_IDLE;
      idx_q    <= '0;
      en_out_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      scan_q   <= scan_d;
      mode_q   <= mode_d;
      z_q      <= z_d;
      idx_q    <= idx_d;
      en_out_q <= en_out_d;
      tick_q   <= tick_d;
    end
  end

  assign z      = z_q;
  assign idx    = idx_q;
  assign en_out = en_out_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
module tb_decoder_scan_n;

`ifdef DECODER_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [1:0] sel;

  logic [3:0] z_a, z_b;
  logic [1:0] idx_a, idx_b;
  logic       en_out_a, en_out_b, tick_a, tick_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Main instance: LAST=2, PRESCALE=4, active-high.
  decoder_scan_n #(.SEL_W(2), .LAST(2), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .z(z_a), .idx(idx_a), .en_out(en_out_a), .tick(tick_a)
  );

  // Corner instance: LAST=0, PRESCALE=1, active-low.
  decoder_scan_n #(.SEL_W(2), .LAST(0), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .z(z_b), .idx(idx_b), .en_out(en_out_b), .tick(tick_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_z(input int index, input bit tk);
    logic [3:0] one;
    one = 4'b0001;
    if (DT && tk) return 4'b0000;
    return one << index;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd3;
    step();
    step();
    checks++;
    if ({z_a, idx_a, tick_a, en_out_a} !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: z=%b idx=%0d tick=%b en_out=%b, want z=0000 idx=0 tick=0 en_out=0",
               z_a, idx_a, tick_a, en_out_a);
    end
    checks++;
    if ({z_b, idx_b, tick_b, en_out_b} !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b_active_low: z=%b idx=%0d tick=%b en_out=%b, want z=1111 idx=0 tick=0 en_out=0",
               z_b, idx_b, tick_b, en_out_b);
    end
  endtask

  task automatic test_direct();
    logic [3:0] one;
    one = 4'b0001;
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      checks++;
      if ({z_a, idx_a, tick_a, en_out_a} !== {one << i, 2'(i), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL direct_a sel=%0d: z=%b idx=%0d tick=%b en_out=%b, want z=%b idx=%0d tick=0 en_out=1",
                 i, z_a, idx_a, tick_a, en_out_a, one << i, i);
      end
      checks++;
      if ({z_b, idx_b} !== {~(one << i), 2'(i)}) begin
        errors++;
        $display("FAIL direct_b sel=%0d: z=%b idx=%0d, want z=%b idx=%0d",
                 i, z_b, idx_b, ~(one << i), i);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if ({z_a, en_out_a, tick_a, z_b, en_out_b} !== {4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL direct_disable: z_a=%b en_out_a=%b tick_a=%b z_b=%b en_out_b=%b, want 0000 0 0 1111 0",
               z_a, en_out_a, tick_a, z_b, en_out_b);
    end
  endtask

  task automatic test_scan_wrap();
    int ei;
    bit et;
    en = 1'b1; mode = 1'b1; sel = 2'd3;
    for (int k = 0; k < 16; k++) begin
      step();
      ei = (k / 4) % 3;
      et = (k > 0) && (k % 4 == 0);
      checks++;
      if ({z_a, idx_a, tick_a, en_out_a} !== {exp_z(ei, et), 2'(ei), et, 1'b1}) begin
        errors++;
        $display("FAIL scan_a k=%0d: z=%b idx=%0d tick=%b en_out=%b, want z=%b idx=%0d tick=%b en_out=1",
                 k, z_a, idx_a, tick_a, en_out_a, exp_z(ei, et), ei, et);
      end
      // PRESCALE=1, LAST=0: index pinned at 0, tick high every cycle after entry.
      et = (k > 0);
      checks++;
      if ({z_b, idx_b, tick_b} !== {DT && et ? 4'b1111 : 4'b1110, 2'd0, et}) begin
        errors++;
        $display("FAIL scan_b k=%0d: z=%b idx=%0d tick=%b, want z=%b idx=0 tick=%b",
                 k, z_b, idx_b, tick_b, DT && et ? 4'b1111 : 4'b1110, et);
      end
    end
  endtask

  task automatic test_enable_pause();
    int ei;
    bit et;
    en = 1'b1; mode = 1'b0; sel = 2'd0;
    step();
    mode = 1'b1;
    // After the 7th step the prescaler sits at 2 with index 1.
    for (int k = 0; k < 7; k++) begin
      step();
      ei = k / 4;
      et = (k == 4);
      checks++;
      if ({z_a, idx_a, tick_a} !== {exp_z(ei, et), 2'(ei), et}) begin
        errors++;
        $display("FAIL pause_lead k=%0d: z=%b idx=%0d tick=%b, want z=%b idx=%0d tick=%b",
                 k, z_a, idx_a, tick_a, exp_z(ei, et), ei, et);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({z_a, tick_a, en_out_a, z_b, tick_b} !== {4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0}) begin
        errors++;
        $display("FAIL pause k=%0d: z_a=%b tick_a=%b en_out_a=%b z_b=%b tick_b=%b, want 0000 0 0 1111 0",
                 k, z_a, tick_a, en_out_a, z_b, tick_b);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if ({z_a, idx_a, tick_a, en_out_a} !== {4'b0010, 2'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL resume_hold: z=%b idx=%0d tick=%b en_out=%b, want z=0010 idx=1 tick=0 en_out=1",
               z_a, idx_a, tick_a, en_out_a);
    end
    step();
    checks++;
    if ({z_a, idx_a, tick_a} !== {exp_z(2, 1'b1), 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL resume_advance: z=%b idx=%0d tick=%b, want z=%b idx=2 tick=1",
               z_a, idx_a, tick_a, exp_z(2, 1'b1));
    end
    step();
    checks++;
    if ({z_a, idx_a, tick_a} !== {4'b0100, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL resume_settle: z=%b idx=%0d tick=%b, want z=0100 idx=2 tick=0",
               z_a, idx_a, tick_a);
    end
  endtask

  task automatic test_mode_switch();
    int ei;
    bit et;
    mode = 1'b0; sel = 2'd3;
    step();
    checks++;
    if ({z_a, idx_a, tick_a} !== {4'b1000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL mode_to_direct: z=%b idx=%0d tick=%b, want z=1000 idx=3 tick=0",
               z_a, idx_a, tick_a);
    end
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      ei = (k == 4) ? 1 : 0;
      et = (k == 4);
      checks++;
      if ({z_a, idx_a, tick_a} !== {exp_z(ei, et), 2'(ei), et}) begin
        errors++;
        $display("FAIL mode_restart k=%0d: z=%b idx=%0d tick=%b, want z=%b idx=%0d tick=%b",
                 k, z_a, idx_a, tick_a, exp_z(ei, et), ei, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Reset mid-scan overrides en/mode.
    rst = 1'b1;
    step();
    checks++;
    if ({z_a, idx_a, tick_a, en_out_a, z_b} !== {4'b0000, 2'd0, 1'b0, 1'b0, 4'b1111}) begin
      errors++;
      $display("FAIL reset_override: z_a=%b idx=%0d tick=%b en_out=%b z_b=%b, want 0000 0 0 0 1111",
               z_a, idx_a, tick_a, en_out_a, z_b);
    end
    rst = 1'b0;
    // Released with mode=1 already high: restarts at index 0 for a full period.
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({idx_a, tick_a} !== {(k == 4) ? 2'd1 : 2'd0, k == 4}) begin
        errors++;
        $display("FAIL post_reset_scan k=%0d: idx=%0d tick=%b, want idx=%0d tick=%b",
                 k, idx_a, tick_a, (k == 4) ? 1 : 0, k == 4);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0;
    test_reset();
    test_direct();
    test_scan_wrap();
    test_enable_pause();
    test_mode_switch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
